// File: rtl/frogger_lane_pkg.sv
// Shared types and constants for the multi-lane obstacle scroller.
// Row type, direction/mode encodings and the refill LFSR constants.
package frogger_lane_pkg;

    localparam int LANE_WIDTH = 16;

    typedef logic [LANE_WIDTH-1:0] lane_row_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_REFILL = 1'b0,
        MODE_ROTATE = 1'b1
    } mode_e;

    // Galois LFSR, taps 16,14,13,11, right-shifting form.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lane_shifter.sv
// One scrolling lane: row register, period counter and the shift/refill pulses.
// Priority each cycle is load, then pause, then refill-on-empty, then shift/count.
module lane_shifter
    import frogger_lane_pkg::*;
#(
    parameter int WIDTH = LANE_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_row,
    input  logic [WIDTH-1:0] refill_val,
    input  logic [CNT_W-1:0] period,
    input  logic             dir,
    input  logic             mode,
    output logic [WIDTH-1:0] row,
    output logic             shift_tick,
    output logic             refill
);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shifted;
    logic             is_rotate;
    logic             is_left;
    logic             row_empty;

    assign is_rotate = (mode_e'(mode) == MODE_ROTATE);
    assign is_left   = (dir_e'(dir) == DIR_LEFT);
    // Registered row is tested, so an emptied row shows for a cycle before refill.
    assign row_empty = (row == '0);

    always_comb begin
        shifted = row;
        if (is_rotate) begin
            if (is_left) begin
                shifted = {row[WIDTH-2:0], row[WIDTH-1]};
            end else begin
                shifted = {row[0], row[WIDTH-1:1]};
            end
        end else begin
            if (is_left) begin
                shifted = row << 1;
            end else begin
                shifted = row >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row        <= '0;
            cnt        <= '0;
            shift_tick <= 1'b0;
            refill     <= 1'b0;
        end else if (load) begin
            row        <= load_row;
            cnt        <= '0;
            shift_tick <= 1'b0;
            refill     <= 1'b0;
        end else if (!enable) begin
            shift_tick <= 1'b0;
            refill     <= 1'b0;
        end else if (!is_rotate && row_empty) begin
            // Counter holds while the lane is refilled.
            row        <= refill_val;
            shift_tick <= 1'b0;
            refill     <= 1'b1;
        end else if (cnt >= period) begin
            row        <= shifted;
            cnt        <= '0;
            shift_tick <= 1'b1;
            refill     <= 1'b0;
        end else begin
            cnt        <= cnt + CNT_W'(1);
            shift_tick <= 1'b0;
            refill     <= 1'b0;
        end
    end

endmodule

// File: rtl/lane_scroller.sv
// Multi-lane row scroller feeding the LED-matrix obstacle map.
// Optional RAND_REFILL_EN masks each lane's refill pattern with a shared LFSR.
module lane_scroller
    import frogger_lane_pkg::*;
#(
    parameter int WIDTH = LANE_WIDTH,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   load,
    input  logic [LANES*WIDTH-1:0] load_rows,
    input  logic [LANES*WIDTH-1:0] pattern,
    input  logic [LANES*CNT_W-1:0] period,
    input  logic [LANES-1:0]       dir,
    input  logic [LANES-1:0]       mode,
    output logic [LANES*WIDTH-1:0] rows_out,
    output logic [LANES-1:0]       shift_tick,
    output logic [LANES-1:0]       refill
);

`ifdef RAND_REFILL_EN
    logic [15:0]      lfsr;
    logic [WIDTH-1:0] lfsr_rep;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else if (enable) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    // LFSR bits replicated (or truncated) across the row width.
    always_comb begin
        lfsr_rep = '0;
        for (int b = 0; b < WIDTH; b++) begin
            lfsr_rep[b] = lfsr[b % 16];
        end
    end
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] pat;
        logic [WIDTH-1:0] refill_val;

        assign pat = pattern[i*WIDTH +: WIDTH];

`ifdef RAND_REFILL_EN
        logic [WIDTH-1:0] masked;
        assign masked     = pat & lfsr_rep;
        // An all-zero mask would leave the lane empty again, so fall back.
        assign refill_val = (masked != '0) ? masked : pat;
`else
        assign refill_val = pat;
`endif

        lane_shifter #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .enable     (enable),
            .load       (load),
            .load_row   (load_rows[i*WIDTH +: WIDTH]),
            .refill_val (refill_val),
            .period     (period[i*CNT_W +: CNT_W]),
            .dir        (dir[i]),
            .mode       (mode[i]),
            .row        (rows_out[i*WIDTH +: WIDTH]),
            .shift_tick (shift_tick[i]),
            .refill     (refill[i])
        );
    end

endmodule
